// File: rtl/sram_pkg.sv
// Shared types and helpers for the banked single-port SRAM model.
package sram_pkg;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

  // A single bank needs no select bits, so the whole address becomes the row.
  function automatic int f_bank_sel_w(input int banks);
    return (banks > 1) ? $clog2(banks) : 0;
  endfunction

  function automatic int f_row_w(input int addr_w, input int banks);
    return addr_w - f_bank_sel_w(banks);
  endfunction

  // Bitwise masked merge: keep the old bit unless the mask selects the new one.
  function automatic logic f_mask_bit(input logic old_bit, input logic new_bit,
                                      input logic mask_bit);
    return mask_bit ? new_bit : old_bit;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// One SRAM bank: row array with a bit-masked write port and a registered read port.
module sram_bank
  import sram_pkg::*;
#(
  parameter int P_DW  = 32,
  parameter int P_RW  = 11,
  parameter int P_RCW = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [P_RCW-1:0]  i_row,
  input  logic [P_DW-1:0]   i_din,
  input  logic [P_DW-1:0]   i_bm,
  output logic [P_DW-1:0]   o_rdata
);

  logic [P_DW-1:0] r_mem [0:(1<<P_RW)-1];
  logic [P_DW-1:0] r_rdata;
  logic [P_DW-1:0] w_wdata;

  // NOTE: every bit is assigned inside the loop, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < P_DW; i++) begin
      w_wdata[i] = f_mask_bit(r_mem[i_row][i], i_din[i], i_bm[i]);
    end
  end

  // NOTE: the array has no reset; clearing it is the init sequencer's job.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_row] <= w_wdata;
  end

  // NOTE: non-blocking assignments keep the read and write ports race-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_row];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_1p_banked_init.sv
// Parametrised banked single-port SRAM with masked writes, optional output
// register, read-valid strobe, error pulse and post-reset zero-init sequencer.
module sram_1p_banked_init
  import sram_pkg::*;
#(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ADDR_WIDTH = 13,
  parameter int P_BANKS      = 4,
  parameter int P_OUT_REG    = 0,
  parameter int P_INIT_ZERO  = 1
) (
  input  logic                    A_CLK,
  input  logic                    A_RST,
  input  logic                    A_MEN,
  input  logic                    A_WEN,
  input  logic                    A_REN,
  input  logic [P_ADDR_WIDTH-1:0] A_ADDR,
  input  logic [P_DATA_WIDTH-1:0] A_DIN,
  input  logic [P_DATA_WIDTH-1:0] A_BM,
  input  logic                    A_DLY,
  output logic [P_DATA_WIDTH-1:0] A_DOUT,
  output logic                    A_DOUT_VLD,
  output logic                    A_BUSY,
  output logic                    A_ERR
);

  localparam int LP_BSW  = f_bank_sel_w(P_BANKS);
  localparam int LP_RW   = f_row_w(P_ADDR_WIDTH, P_BANKS);
  localparam int LP_BCW  = (LP_BSW > 0) ? LP_BSW : 1;
  localparam int LP_RCW  = (LP_RW > 0) ? LP_RW : 1;
  localparam int LP_ROWS = 1 << LP_RW;
  localparam logic [LP_RCW-1:0] LP_LAST_ROW = LP_RCW'(LP_ROWS - 1);

  state_e              r_state, w_state_nxt;
  logic [LP_RCW-1:0]   r_cnt;
  logic                w_busy;
  logic [LP_BCW-1:0]   w_bank, r_sel;
  logic [LP_RCW-1:0]   w_row;
  logic                w_wr_acc, w_rd_acc, w_err;
  logic                r_vld1, r_err;
  logic [P_DATA_WIDTH-1:0] w_rdata [P_BANKS];
  logic [P_DATA_WIDTH-1:0] w_mux;

  // Low-order interleave: bottom address bits pick the bank.
  generate
    if (LP_BSW > 0) begin : g_bsel
      assign w_bank = A_ADDR[LP_BSW-1:0];
    end else begin : g_nobsel
      assign w_bank = '0;
    end
    if (LP_RW > 0) begin : g_row
      assign w_row = A_ADDR[P_ADDR_WIDTH-1:LP_BSW];
    end else begin : g_norow
      assign w_row = '0;
    end
  endgenerate

  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) r_state <= (P_INIT_ZERO != 0) ? ST_INIT : ST_READY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && r_cnt == LP_LAST_ROW) w_state_nxt = ST_READY;
  end

  always_comb begin
    w_busy = (r_state == ST_INIT);
  end

  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST)       r_cnt <= '0;
    else if (w_busy) r_cnt <= r_cnt + 1'b1;
  end

  // A collision still performs the write; only the read half is dropped.
  assign w_wr_acc = !w_busy && A_MEN && A_WEN;
  assign w_rd_acc = !w_busy && A_MEN && A_REN && !A_WEN;
  assign w_err    = w_busy ? (A_MEN && (A_WEN || A_REN)) : (A_MEN && A_WEN && A_REN);

  genvar b;
  generate
    for (b = 0; b < P_BANKS; b++) begin : g_bank
      logic w_hit;
      assign w_hit = (w_bank == LP_BCW'(b));
      sram_bank #(
        .P_DW  (P_DATA_WIDTH),
        .P_RW  (LP_RW),
        .P_RCW (LP_RCW)
      ) u_bank (
        .clk     (A_CLK),
        .rst     (A_RST),
        .i_we    (w_busy || (w_wr_acc && w_hit)),
        .i_re    (w_rd_acc && w_hit),
        .i_row   (w_busy ? r_cnt : w_row),
        .i_din   (w_busy ? '0 : A_DIN),
        .i_bm    (w_busy ? '1 : A_BM),
        .o_rdata (w_rdata[b])
      );
    end
  endgenerate

  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      r_sel  <= '0;
      r_vld1 <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_rd_acc) r_sel <= w_bank;
      r_vld1 <= w_rd_acc;
      r_err  <= w_err;
    end
  end

  // The bank read registers hold between reads, so the mux output holds too.
  assign w_mux = w_rdata[r_sel];

  generate
    if (P_OUT_REG != 0) begin : g_oreg
      logic [P_DATA_WIDTH-1:0] r_dout_q;
      logic                    r_vld2;
      always_ff @(posedge A_CLK or posedge A_RST) begin
        if (A_RST) begin
          r_dout_q <= '0;
          r_vld2   <= 1'b0;
        end else begin
          if (r_vld1) r_dout_q <= w_mux;
          r_vld2 <= r_vld1;
        end
      end
      assign A_DOUT     = r_dout_q;
      assign A_DOUT_VLD = r_vld2;
    end else begin : g_noreg
      assign A_DOUT     = w_mux;
      assign A_DOUT_VLD = r_vld1;
    end
  endgenerate

  assign A_BUSY = w_busy;
  assign A_ERR  = r_err;

endmodule
